// File: rtl/fog_mod_demod_v2.sv
// Fibre-optic gyro square-wave modulator and synchronous demodulator.
//
// Drives a two-level modulation waveform (POS half, then NEG half) and demodulates
// the ADC stream against it. Each period's demodulated sum is averaged over
// 2^avg_sel periods, offset, saturated and presented with a one-clock strobe.
//
// Ports:
//   CLOCK_CPU       clock, all logic on the rising edge
//   RST             asynchronous active-high reset
//   ADC             signed sample, one per clock
//   i_enable        1 = run, 0 = return to IDLE on the next clock
//   var_freq_cnt    half-period length in clocks (values below 2 act as 2)
//   var_amp_H/L     unsigned magnitudes of the positive / negative levels
//   var_polarity    1 inverts the demodulation sign
//   var_wait_cnt    samples blanked at the start of each half
//   var_err_offset  signed offset added to the averaged error
//   var_avg_sel     log2 of the averaging length (values above 15 act as 15)
//   o_mod_out_DAC   registered modulation level
//   o_err_DAC       registered, saturated averaged error
//   o_err_valid     one-clock strobe per new o_err_DAC
//   o_busy          1 whenever the state is not IDLE
module fog_mod_demod_v2 #(
  parameter int unsigned ADC_W = 14,
  parameter int unsigned MOD_W = 16,
  parameter int unsigned ERR_W = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                    CLOCK_CPU,
  input  logic                    RST,
  input  logic signed [ADC_W-1:0] ADC,
  input  logic                    i_enable,
  input  logic [CNT_W-1:0]        var_freq_cnt,
  input  logic [MOD_W-1:0]        var_amp_H,
  input  logic [MOD_W-1:0]        var_amp_L,
  input  logic                    var_polarity,
  input  logic [CNT_W-1:0]        var_wait_cnt,
  input  logic signed [ERR_W-1:0] var_err_offset,
  input  logic [4:0]              var_avg_sel,
  output logic signed [MOD_W-1:0] o_mod_out_DAC,
  output logic signed [ERR_W-1:0] o_err_DAC,
  output logic                    o_err_valid,
  output logic                    o_busy
);

  localparam int unsigned PSUM_W = ADC_W + CNT_W + 1;
  localparam int unsigned ACC_W  = ADC_W + CNT_W + 17;
  localparam int unsigned SUM_W  = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;
  localparam int unsigned PCNT_W = 17;

  localparam logic signed [SUM_W-1:0] ERR_MAX = {{(SUM_W-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ERR_MIN = {{(SUM_W-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};
  localparam logic signed [MOD_W-1:0] MOD_MAX = {1'b0, {(MOD_W-1){1'b1}}};
  localparam logic signed [MOD_W-1:0] MOD_MIN = {1'b1, {(MOD_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StPos, StNeg} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        freq_q, wait_q, freq_in;
  logic [3:0]              sel_q, sel_in;
  logic                    pol_q;
  logic signed [ERR_W-1:0] off_q;
  logic signed [MOD_W-1:0] lvl_h_q, lvl_l_q, lvl_h_in, lvl_l_in;
  logic signed [PSUM_W-1:0] psum_q, sample_ext, contrib, psum_fin;
  logic signed [ACC_W-1:0]  acc_q, acc_fin, acc_shr;
  logic [PCNT_W-1:0]       pcnt_q, pcnt_fin;
  logic signed [SUM_W-1:0] err_raw;
  logic signed [ERR_W-1:0] err_sat;
  logic                    half_end, keep, negate, avg_done, latch;

  assign o_busy = (state_q != StIdle);

  always_comb begin
    // Shadow values are sanitised once, at latch time.
    freq_in  = (var_freq_cnt < CNT_W'(2)) ? CNT_W'(2) : var_freq_cnt;
    sel_in   = (var_avg_sel > 5'd15) ? 4'd15 : var_avg_sel[3:0];
    lvl_h_in = var_amp_H[MOD_W-1] ? MOD_MAX : $signed(var_amp_H);
    lvl_l_in = var_amp_L[MOD_W-1] ? MOD_MIN : -$signed(var_amp_L);

    half_end   = (cnt_q == freq_q - CNT_W'(1));
    keep       = (cnt_q >= wait_q);
    negate     = (state_q == StNeg) ^ pol_q;
    sample_ext = {{(PSUM_W-ADC_W){ADC[ADC_W-1]}}, ADC};
    contrib    = '0;
    if (keep) begin
      contrib = negate ? -sample_ext : sample_ext;
    end
    psum_fin = psum_q + contrib;

    // Period close: include the final NEG sample taken on this edge.
    acc_fin  = acc_q + {{(ACC_W-PSUM_W){psum_fin[PSUM_W-1]}}, psum_fin};
    pcnt_fin = pcnt_q + PCNT_W'(1);
    avg_done = (pcnt_fin == (PCNT_W'(1) << sel_q));
    acc_shr  = acc_fin >>> sel_q;
    err_raw  = {{(SUM_W-ACC_W){acc_shr[ACC_W-1]}}, acc_shr}
             + {{(SUM_W-ERR_W){off_q[ERR_W-1]}}, off_q};
    if (err_raw > ERR_MAX) begin
      err_sat = ERR_MAX[ERR_W-1:0];
    end else if (err_raw < ERR_MIN) begin
      err_sat = ERR_MIN[ERR_W-1:0];
    end else begin
      err_sat = err_raw[ERR_W-1:0];
    end

    latch = i_enable && ((state_q == StIdle) || ((state_q == StNeg) && half_end));
  end

  always_ff @(posedge CLOCK_CPU or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      psum_q        <= '0;
      acc_q         <= '0;
      pcnt_q        <= '0;
      freq_q        <= CNT_W'(2);
      wait_q        <= '0;
      sel_q         <= '0;
      pol_q         <= 1'b0;
      off_q         <= '0;
      lvl_h_q       <= '0;
      lvl_l_q       <= '0;
      o_mod_out_DAC <= '0;
      o_err_DAC     <= '0;
      o_err_valid   <= 1'b0;
    end else begin
      o_err_valid <= 1'b0;
      if (latch) begin
        freq_q  <= freq_in;
        wait_q  <= var_wait_cnt;
        sel_q   <= sel_in;
        pol_q   <= var_polarity;
        off_q   <= var_err_offset;
        lvl_h_q <= lvl_h_in;
        lvl_l_q <= lvl_l_in;
      end
      if (!i_enable) begin
        // Partial sums are dropped; o_err_DAC keeps its last value.
        state_q       <= StIdle;
        cnt_q         <= '0;
        psum_q        <= '0;
        acc_q         <= '0;
        pcnt_q        <= '0;
        o_mod_out_DAC <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q       <= StPos;
            cnt_q         <= '0;
            psum_q        <= '0;
            acc_q         <= '0;
            pcnt_q        <= '0;
            o_mod_out_DAC <= lvl_h_in;
          end
          StPos: begin
            psum_q <= psum_fin;
            if (half_end) begin
              state_q       <= StNeg;
              cnt_q         <= '0;
              o_mod_out_DAC <= lvl_l_q;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          StNeg: begin
            if (half_end) begin
              state_q       <= StPos;
              cnt_q         <= '0;
              psum_q        <= '0;
              o_mod_out_DAC <= lvl_h_in;
              if (avg_done) begin
                o_err_DAC   <= err_sat;
                o_err_valid <= 1'b1;
                acc_q       <= '0;
                pcnt_q      <= '0;
              end else begin
                acc_q  <= acc_fin;
                pcnt_q <= pcnt_fin;
              end
              // A new averaging length restarts the average (overrides the above).
              if (sel_in != sel_q) begin
                acc_q  <= '0;
                pcnt_q <= '0;
              end
            end else begin
              psum_q <= psum_fin;
              cnt_q  <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fog_mod_demod_v2.sv
`timescale 1ns/1ps
module tb_fog_mod_demod_v2;

  typedef struct {
    logic [31:0]        freq;
    logic [31:0]        wait_c;
    logic [15:0]        amp_h;
    logic [15:0]        amp_l;
    logic               pol;
    logic signed [31:0] offset;
    logic [4:0]         sel;
  } cfg_t;

  logic               clk;
  logic               rst;
  logic signed [13:0] adc;
  logic               en;
  logic [31:0]        freq, wait_c;
  logic [15:0]        amp_h, amp_l;
  logic               pol;
  logic signed [31:0] offset;
  logic signed [7:0]  off8;
  logic [4:0]         sel;

  logic signed [15:0] mod32, mod8;
  logic signed [31:0] err32;
  logic signed [7:0]  err8;
  logic               valid32, valid8, busy32, busy8;

  assign off8 = offset[7:0];

  fog_mod_demod_v2 dut (
    .CLOCK_CPU(clk), .RST(rst), .ADC(adc), .i_enable(en), .var_freq_cnt(freq),
    .var_amp_H(amp_h), .var_amp_L(amp_l), .var_polarity(pol), .var_wait_cnt(wait_c),
    .var_err_offset(offset), .var_avg_sel(sel), .o_mod_out_DAC(mod32), .o_err_DAC(err32),
    .o_err_valid(valid32), .o_busy(busy32)
  );

  fog_mod_demod_v2 #(.ERR_W(8)) dut8 (
    .CLOCK_CPU(clk), .RST(rst), .ADC(adc), .i_enable(en), .var_freq_cnt(freq),
    .var_amp_H(amp_h), .var_amp_L(amp_l), .var_polarity(pol), .var_wait_cnt(wait_c),
    .var_err_offset(off8), .var_avg_sel(sel), .o_mod_out_DAC(mod8), .o_err_DAC(err8),
    .o_err_valid(valid8), .o_busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  longint exp32_q[$];
  longint exp8_q[$];
  int     strobes32 = 0;
  longint last_err32 = 0;
  longint last_err8 = 0;
  longint last_exp32 = 0;
  longint last_exp8 = 0;
  longint m_acc = 0;
  int     m_pcnt = 0;
  cfg_t   seq_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules, written from the behavioural description.
  function automatic int f_eff(input cfg_t c);
    return (c.freq < 2) ? 2 : int'(c.freq);
  endfunction
  function automatic int sel_eff(input cfg_t c);
    return (c.sel > 15) ? 15 : int'(c.sel);
  endfunction
  function automatic longint lvl_h(input cfg_t c);
    return (c.amp_h > 16'd32767) ? 32767 : longint'(c.amp_h);
  endfunction
  function automatic longint lvl_l(input cfg_t c);
    return (c.amp_l > 16'd32768) ? -32768 : -longint'(c.amp_l);
  endfunction
  function automatic longint sat(input longint v, input int w);
    longint mx, mn;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    return (v > mx) ? mx : ((v < mn) ? mn : v);
  endfunction
  function automatic cfg_t mk_cfg(input int fr, input int wt, input int ah, input int al,
                                  input bit p, input int off, input int s);
    cfg_t c;
    c.freq = 32'(fr); c.wait_c = 32'(wt); c.amp_h = 16'(ah); c.amp_l = 16'(al);
    c.pol = p; c.offset = 32'(off); c.sel = 5'(s);
    return c;
  endfunction
  function automatic cfg_t rnd_cfg(input int s);
    return mk_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 200)) - 100, s);
  endfunction

  task automatic drive_cfg(input cfg_t c);
    freq = c.freq; wait_c = c.wait_c; amp_h = c.amp_h; amp_l = c.amp_l;
    pol = c.pol; offset = c.offset; sel = c.sel;
  endtask

  // One modulation period: drives 2F samples, checks the level, models the sum.
  // mode 1 = square input (+a in POS, -a in NEG), mode 0 = random samples.
  task automatic run_period(input cfg_t cur, input cfg_t nxt, input int mode, input int a,
                            input int chg, input int abort_at, output bit aborted);
    int F, s, idx, se;
    longint psum, e;
    bit neg;
    F = f_eff(cur);
    psum = 0;
    aborted = 1'b0;
    for (int k = 0; k < 2 * F; k++) begin
      @(negedge clk);
      check("mod_level", longint'(mod32), (k < F) ? lvl_h(cur) : lvl_l(cur));
      if (k == 0) check("busy_run", longint'(busy32), 1);
      if (k == abort_at) begin
        en = 1'b0;
        aborted = 1'b1;
        m_acc = 0;
        m_pcnt = 0;
        return;
      end
      if (mode == 1) s = (k < F) ? a : -a;
      else s = int'($urandom_range(0, 16383)) - 8192;
      adc = 14'(s);
      idx = (k < F) ? k : k - F;
      if (idx >= int'(cur.wait_c)) begin
        neg = (k >= F) ^ cur.pol;
        psum += neg ? -longint'(s) : longint'(s);
      end
      if (k == chg) drive_cfg(nxt);
    end
    se = sel_eff(cur);
    m_acc += psum;
    m_pcnt++;
    if (m_pcnt == (1 << se)) begin
      e = (m_acc >>> se) + longint'(cur.offset);
      last_exp32 = sat(e, 32);
      last_exp8 = sat(e, 8);
      exp32_q.push_back(last_exp32);
      exp8_q.push_back(last_exp8);
      m_acc = 0;
      m_pcnt = 0;
    end
    if (sel_eff(nxt) != se) begin
      m_acc = 0;
      m_pcnt = 0;
    end
  endtask

  // Runs every config in seq_q as consecutive periods, then disables.
  task automatic run_seq(input int mode, input int a, input int chg_fixed, input int abort_at);
    cfg_t cur, nxt;
    bit ab;
    int chg;
    ab = 1'b0;
    @(negedge clk);
    drive_cfg(seq_q[0]);
    en = 1'b1;
    for (int i = 0; i < seq_q.size(); i++) begin
      cur = seq_q[i];
      nxt = (i + 1 < seq_q.size()) ? seq_q[i+1] : seq_q[i];
      chg = (chg_fixed >= 0) ? chg_fixed : int'($urandom_range(1, 2 * f_eff(cur) - 1));
      run_period(cur, nxt, mode, a, chg, (i == seq_q.size() - 1) ? abort_at : -1, ab);
      if (ab) break;
    end
    if (!ab) begin
      @(negedge clk);
      en = 1'b0;
      m_acc = 0;
      m_pcnt = 0;
    end
    @(negedge clk);
    check("idle_busy", longint'(busy32), 0);
    check("idle_mod", longint'(mod32), 0);
    check("err_hold32", longint'(err32), last_exp32);
    check("err_hold8", longint'(err8), last_exp8);
  endtask

  // Scoreboard monitor: every strobe consumes one expected value.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid32) begin
        strobes32++;
        last_err32 = err32;
        if (exp32_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL strobe32: unexpected strobe, got %0d, expected none", err32);
        end else begin
          check("err32", longint'(err32), exp32_q.pop_front());
        end
      end
      if (valid8) begin
        last_err8 = err8;
        if (exp8_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL strobe8: unexpected strobe, got %0d, expected none", err8);
        end else begin
          check("err8", longint'(err8), exp8_q.pop_front());
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_t ca, cap, cb, c4, c6, cd, cdp;
    bit   ab;
    int   s0, base_sel, nper, last_f, abort_at;

    rst = 1'b1; en = 1'b0; adc = '0;
    drive_cfg(mk_cfg(0, 0, 0, 0, 1'b0, 0, 0));
    repeat (2) @(negedge clk);
    check("rst_mod", longint'(mod32), 0);
    check("rst_err", longint'(err32), 0);
    check("rst_valid", longint'(valid32), 0);
    check("rst_busy", longint'(busy32), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_enable", longint'(busy32), 0);

    // Basic square-wave demodulation, then inverted polarity.
    ca  = mk_cfg(4, 0, 1000, 1000, 1'b0, 0, 0);
    cap = mk_cfg(4, 0, 1000, 1000, 1'b1, 0, 0);
    s0 = strobes32;
    seq_q = '{ca, ca, ca};
    run_seq(1, 100, -1, -1);
    check("basic_strobes", strobes32 - s0, 3);
    check("basic_err", last_err32, 800);
    s0 = strobes32;
    seq_q = '{cap, cap};
    run_seq(1, 100, -1, -1);
    check("pol_strobes", strobes32 - s0, 2);
    check("pol_err", last_err32, -800);

    // Blanking, 4-period average and negative offset.
    cb = mk_cfg(4, 2, 1000, 1000, 1'b0, -5, 2);
    s0 = strobes32;
    seq_q = '{cb, cb, cb, cb, cb, cb, cb, cb};
    run_seq(1, 100, -1, -1);
    check("avg_strobes", strobes32 - s0, 2);
    check("avg_err", last_err32, 395);

    // Half-period change mid-POS only applies from the next period.
    c4 = mk_cfg(4, 0, 1000, 1000, 1'b0, 0, 0);
    c6 = mk_cfg(6, 0, 1000, 1000, 1'b0, 0, 0);
    s0 = strobes32;
    seq_q = '{c4, c6, c6};
    run_seq(1, 100, 1, -1);
    check("freq_chg_strobes", strobes32 - s0, 3);
    check("freq_chg_err", last_err32, 1200);

    // Saturation on the narrow-error instance.
    cd  = mk_cfg(4, 0, 1000, 1000, 1'b0, 0, 0);
    cdp = mk_cfg(4, 0, 1000, 1000, 1'b1, 0, 0);
    seq_q = '{cd, cd};
    run_seq(1, 8191, -1, -1);
    check("sat_pos8", last_err8, 127);
    check("sat_wide", last_err32, 65528);
    seq_q = '{cdp};
    run_seq(1, 8191, -1, -1);
    check("sat_neg8", last_err8, -128);

    // Reset in the middle of a NEG half.
    @(negedge clk);
    drive_cfg(ca);
    en = 1'b1;
    run_period(ca, ca, 1, 100, 1, -1, ab);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      adc = (k < 4) ? 14'sd100 : -14'sd100;
    end
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    #1;
    check("rstmid_mod", longint'(mod32), 0);
    check("rstmid_err", longint'(err32), 0);
    check("rstmid_err8", longint'(err8), 0);
    check("rstmid_valid", longint'(valid32), 0);
    check("rstmid_busy", longint'(busy32), 0);
    m_acc = 0; m_pcnt = 0; last_exp32 = 0; last_exp8 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_stay_idle", longint'(busy32), 0);
    s0 = strobes32;
    seq_q = '{ca, ca};
    run_seq(1, 100, -1, -1);
    check("rstmid_strobes", strobes32 - s0, 2);
    check("rstmid_clean_err", last_err32, 800);

    // Randomised runs, with occasional averaging-length changes and aborts.
    for (int r = 0; r < 30; r++) begin
      nper = int'($urandom_range(1, 12));
      base_sel = int'($urandom_range(0, 2));
      seq_q.delete();
      for (int p = 0; p < nper; p++) begin
        seq_q.push_back(rnd_cfg(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3))
                                                             : base_sel));
      end
      last_f = f_eff(seq_q[nper-1]);
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * last_f - 1)) : -1;
      run_seq(0, 0, -1, abort_at);
    end

    repeat (3) @(negedge clk);
    check("pending32", exp32_q.size(), 0);
    check("pending8", exp8_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fog_mod_demod_v2.md
FOG_MOD_DEMOD_V2 -- requirements
Module: fog_mod_demod_v2

Interface
REQ-001 SHALL have parameter ADC_W, default 14: signed ADC sample width.
REQ-002 SHALL have parameter MOD_W, default 16: signed modulation output width.
REQ-003 SHALL have parameter ERR_W, default 32: signed error output width.
REQ-004 SHALL have parameter CNT_W, default 32: width of all timing counters.
REQ-005 SHALL have port CLOCK_CPU  in  1: single clock; all logic rising-edge.
REQ-006 SHALL have port RST  in  1: reset, asynchronous assert, active-high.
REQ-007 SHALL have port ADC  in  ADC_W: signed sample, one sample per clock.
REQ-008 SHALL have port i_enable  in  1: run when 1, return to IDLE when 0.
REQ-009 SHALL have port var_freq_cnt  in  CNT_W: half-period length in clocks.
REQ-010 SHALL have ports var_amp_H, var_amp_L  in  MOD_W: positive and negative magnitudes, unsigned.
REQ-011 SHALL have port var_polarity  in  1: 1 inverts demodulation sign.
REQ-012 SHALL have port var_wait_cnt  in  CNT_W: samples blanked at start of each half.
REQ-013 SHALL have port var_err_offset  in  ERR_W: signed offset added to error.
REQ-014 SHALL have port var_avg_sel  in  5: average over 2^var_avg_sel periods, range 0..15.
REQ-015 SHALL have port o_mod_out_DAC  out  MOD_W: signed modulation level.
REQ-016 SHALL have port o_err_DAC  out  ERR_W: signed averaged error.
REQ-017 SHALL have port o_err_valid  out  1: one-clock strobe per new o_err_DAC.
REQ-018 SHALL have port o_busy  out  1: 1 whenever state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, POS, NEG: IDLE->POS when i_enable=1; POS->NEG and NEG->POS at half-period terminal count; any state->IDLE when i_enable=0, in the next clock.
REQ-020 SHALL latch all var_* inputs into shadow registers on IDLE->POS and on every NEG->POS; mid-period input changes take effect only from the next period.
REQ-021 SHALL treat a shadow freq_cnt below 2 as 2.
REQ-022 SHALL count the half-period counter 0..freq_cnt-1, resetting to 0 on each half transition.
REQ-023 SHALL register o_mod_out_DAC: +amp_H in POS, -amp_L in NEG, 0 in IDLE, clamped to MOD_W signed range.
REQ-024 SHALL discard samples with counter < wait_cnt; wait_cnt >= freq_cnt discards the whole half, contributing 0.
REQ-025 SHALL add non-blanked samples in POS and subtract them in NEG, inverting both signs when polarity=1, into a period sum of width ADC_W+CNT_W+1.
REQ-026 SHALL add the period sum at each NEG->POS into an average accumulator of width ADC_W+CNT_W+17, and count completed periods.
REQ-027 SHALL, when 2^avg_sel periods are complete, form (accumulator arithmetic-shifted right by avg_sel) + err_offset, saturate to ERR_W, register it on o_err_DAC, pulse o_err_valid, and clear accumulator and period count, all in the clock after the last NEG sample.
REQ-028 SHALL restart averaging (clear accumulator and count, no strobe) when a latched avg_sel differs from the previous one.
REQ-029 SHALL, on i_enable=0, discard partial sums and the period count, with o_err_DAC holding its last value.
REQ-030 SHALL treat avg_sel > 15 as 15.

Reset
REQ-031 SHALL, on RST=1, immediately force state IDLE, all counters and sums 0, o_mod_out_DAC=0, o_err_DAC=0, o_err_valid=0, o_busy=0.
REQ-032 SHALL, after RST deasserts mid-operation, remain in IDLE until i_enable is sampled 1.

Verification
REQ-033 SHALL cover: freq_cnt=4, amp_H=amp_L=1000, enable -> o_mod_out_DAC repeats +1000 x4, -1000 x4; o_busy=1.
REQ-034 SHALL cover: ADC=+100 in POS, -100 in NEG, wait=0, avg_sel=0, offset=0 -> o_err_DAC=800 each period, one strobe per period; polarity=1 -> -800.
REQ-035 SHALL cover: same stimulus, wait_cnt=2, avg_sel=2, offset=-5 -> one strobe every 4 periods, o_err_DAC=395.
REQ-036 SHALL cover: ERR_W=8, ADC=8191 constant-signed pattern yielding sum>127 -> o_err_DAC=127; negative case -> -128.
REQ-037 SHALL cover: freq_cnt changed from 4 to 6 mid-POS -> the current period stays 4+4; the next period is 6+6.
REQ-038 SHALL cover: RST pulse mid-NEG -> all outputs 0 in the same cycle; the period after re-enable is clean, with no stale sum in the first o_err_DAC.
